vdu_crtc: RTL and testbench
===========================

// Module: vdu_crtc
// PURPOSE
//  Parametrised successor to the 80x30 text VDU timing generator. Generates character-clocked
//  video timing (de/hs/vs), character row and RAM address for the text pipeline.
//  Adds hardware scroll (start address), a hardware blinking cursor, sync polarity selection
//  and a frame-start strobe. Sits between the ph0 character-clock divider and the
//  glyph ROM / attribute pipeline.
// PARAMETERS
//  H_ACTIVE 80    visible character columns per line; also the RAM stride per text line
//  H_FP 2 / H_SYNC 12 / H_BP 6   horizontal front porch, sync and back porch, in characters
//  ROW_LINES 16   scanlines per character row
//  V_ROWS 30      visible text lines
//  V_FP 10 / V_SYNC 2 / V_BP 33  vertical front porch, sync and back porch, in scanlines
//  ADDR_W 13      video_address width; addresses wrap modulo 2^ADDR_W
//  HS_POL 1       hs active level (1: active-high); VS_POL 1 is the same for vs
//  CUR_START 14 / CUR_END 15     first and last character row (scanline in cell) of the cursor block
//  BLINK_FRAMES 16  frames per cursor blink half-period; 0 = steady cursor
// PORTS
//  clk            in   1       system clock
//  rst            in   1       synchronous reset, active-high
//  ph0            in   1       character clock phase from the divider
//  sec_in         in   1       secondary latch input, passed through
//  ph1            out  1       ph0 delayed one stage (ph0_detect[0] registered)
//  sec_out        out  1       sec_in registered
//  start_addr_we  in   1       write strobe for start_addr_in
//  start_addr_in  in   ADDR_W  new screen start address (shadowed)
//  cursor_we      in   1       write strobe for cursor_addr_in
//  cursor_addr_in in   ADDR_W  cursor RAM address
//  cursor_en      in   1       cursor enable (level)
//  de             out  1       display enable
//  hs, vs         out  1       syncs at the polarity set by HS_POL / VS_POL
//  cursor         out  1       cursor overlay for the current character cell
//  frame_start    out  1       one-clk pulse on the tick that wraps to scanline 0
//  row_out        out  $clog2(ROW_LINES)  character row (scanline within the cell)
//  video_address  out  ADDR_W  RAM address of the current character
// BEHAVIOUR
//  - ph0_detect <= {ph0_detect[0],ph0} every clk. tick = (ph0_detect==2'b01).
//    All counters and the de/hs/vs/cursor/video_address outputs change only on tick.
//  - Counters: column (0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), row (0..ROW_LINES-1),
//    line (0..V_ROWS-1), scanline (0..V_TOTAL-1, V_TOTAL=ROW_LINES*V_ROWS+V_FP+V_SYNC+V_BP).
//    Counter widths are $clog2 of each range.
//  - Counter wrap rules: column wraps at H_TOTAL-1. On column wrap, row increments and wraps
//    at ROW_LINES-1. On row wrap, line increments and holds at V_ROWS-1.
//    On scanline wrap (V_TOTAL-1): row, line and line_base reload and frame_start pulses.
//  - Outputs on each tick are registered from the pre-increment counters:
//    de = column<H_ACTIVE && line<V_ROWS && scanline<ROW_LINES*V_ROWS.
//    hs active for H_ACTIVE+H_FP <= column < H_ACTIVE+H_FP+H_SYNC.
//    vs active for ROW_LINES*V_ROWS+V_FP <= scanline < that value + V_SYNC.
//    video_address = (line_base + column) mod 2^ADDR_W.
//  - line_base: loads active_start at frame start. On every row wrap while line<V_ROWS-1,
//    line_base += H_ACTIVE (mod 2^ADDR_W).
//  - start_addr_we writes a shadow register at any clk. The shadow is copied to active_start
//    only at scanline wrap (no tearing). A write in the same clk as the wrap is loaded.
//  - cursor_we latches cursor_addr at any clk.
//    cursor = cursor_en & blink_on & de_next & (addr_next==cursor_addr)
//             & (CUR_START<=row<=CUR_END).
//    de_next and addr_next are the values registered onto de and video_address on the same
//    tick, so cursor is aligned with de and video_address.
//  - Blink: a frame counter advances at each scanline wrap. blink_on toggles every
//    BLINK_FRAMES frames. If BLINK_FRAMES==0, blink_on is held at 1.
//  - ph1 <= ph0_detect[0] and sec_out <= sec_in every clk, independent of tick.
//  - Reset (overrides tick and writes, valid mid-frame):
//    all counters, ph0_detect, line_base, shadow, active_start, cursor_addr, frame counter = 0.
//    blink_on=1; de=0; cursor=0; frame_start=0; video_address=0; ph1=0; sec_out=0.
//    hs = !HS_POL; vs = !VS_POL.
// TESTING
//  1 Defaults, ph0 period 4 clk -> hs active ticks at columns 82..93 (12 ticks); line = 100 ticks;
//    vs active scanlines 490..491; frame = 525 scanlines; frame_start exactly once per frame.
//  2 Defaults, start 0 -> de only for columns 0..79 and scanlines 0..479;
//    addr at text line 1 col 0 = 80; last visible addr = 2399; row_out cycles 0..15.
//  3 Write start 0x1F00 mid-frame -> current frame unchanged; next frame line 0 col 0 = 0x1F00;
//    line 4 col 0 wraps to 64.
//  4 cursor_addr=85, cursor_en=1 -> cursor high at line 1 col 5, rows 14..15 only;
//    off for 16 frames and on for 16 frames alternately. cursor_en=0 -> never high.
//  5 rst pulsed mid-frame -> next clk all outputs at reset values; first tick after release
//    gives addr 0, de=1.
//  6 HS_POL=0, VS_POL=0 -> hs/vs idle high and pulse low at the same counts as scenario 1.

Source files
------------

// File: rtl/vdu_crtc.sv
// Character-clocked text VDU timing generator: de/hs/vs, character row and RAM address,
// with shadowed hardware scroll, blinking block cursor, sync polarity and frame-start strobe.
module vdu_crtc #(
    parameter int H_ACTIVE     = 80,
    parameter int H_FP         = 2,
    parameter int H_SYNC       = 12,
    parameter int H_BP         = 6,
    parameter int ROW_LINES    = 16,
    parameter int V_ROWS       = 30,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int ADDR_W       = 13,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int CUR_START    = 14,
    parameter int CUR_END      = 15,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ph0,
    input  logic                         sec_in,
    output logic                         ph1,
    output logic                         sec_out,
    input  logic                         start_addr_we,
    input  logic [ADDR_W-1:0]            start_addr_in,
    input  logic                         cursor_we,
    input  logic [ADDR_W-1:0]            cursor_addr_in,
    input  logic                         cursor_en,
    output logic                         de,
    output logic                         hs,
    output logic                         vs,
    output logic                         cursor,
    output logic                         frame_start,
    output logic [$clog2(ROW_LINES)-1:0] row_out,
    output logic [ADDR_W-1:0]            video_address
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_VIS   = ROW_LINES * V_ROWS;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int COL_W   = $clog2(H_TOTAL);
    localparam int ROW_W   = $clog2(ROW_LINES);
    localparam int LINE_W  = $clog2(V_ROWS);
    localparam int SCAN_W  = $clog2(V_TOTAL);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COL_W-1:0]   COL_LAST     = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0]   COL_DE_END   = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]   HS_BEGIN     = COL_W'(H_ACTIVE + H_FP);
    localparam logic [COL_W-1:0]   HS_END       = COL_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [ROW_W-1:0]   ROW_LAST     = ROW_W'(ROW_LINES - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST    = LINE_W'(V_ROWS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST    = SCAN_W'(V_TOTAL - 1);
    localparam logic [SCAN_W-1:0]  SCAN_DE_END  = SCAN_W'(V_VIS);
    localparam logic [SCAN_W-1:0]  VS_BEGIN     = SCAN_W'(V_VIS + V_FP);
    localparam logic [SCAN_W-1:0]  VS_END       = SCAN_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0]  STRIDE       = ADDR_W'(H_ACTIVE);
    localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_FRAMES - 1);

    // One bit per scanline-in-cell: set where the cursor block is drawn.
    function automatic logic [ROW_LINES-1:0] cursor_rows();
        logic [ROW_LINES-1:0] m;
        m = '0;
        for (int i = 0; i < ROW_LINES; i++) m[i] = (i >= CUR_START) && (i <= CUR_END);
        return m;
    endfunction
    localparam logic [ROW_LINES-1:0] CUR_ROWS = cursor_rows();

    logic [1:0]         ph0_detect_q, ph0_detect_d;
    logic               ph1_q, ph1_d;
    logic               sec_out_q, sec_out_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [ADDR_W-1:0]  line_base_q, line_base_d;
    logic [ADDR_W-1:0]  shadow_q, shadow_d;
    logic [ADDR_W-1:0]  cursor_addr_q, cursor_addr_d;
    logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               de_q, de_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               cursor_q, cursor_d;
    logic               frame_start_q, frame_start_d;
    logic [ROW_W-1:0]   row_out_q, row_out_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               tick;
    logic               de_next;
    logic               hs_act;
    logic               vs_act;
    logic [ADDR_W-1:0]  addr_next;

    assign tick = (ph0_detect_q == 2'b01);

    // line < V_ROWS is implied: line saturates at V_ROWS-1 and is only reloaded, never exceeded.
    assign de_next   = (col_q < COL_DE_END) && (scan_q < SCAN_DE_END);
    assign hs_act    = (col_q >= HS_BEGIN) && (col_q < HS_END);
    assign vs_act    = (scan_q >= VS_BEGIN) && (scan_q < VS_END);
    assign addr_next = line_base_q + ADDR_W'(col_q);

    always_comb begin
        // NOTE: every _d is given its hold value first, so no branch can leave a latch behind.
        ph0_detect_d  = {ph0_detect_q[0], ph0};
        ph1_d         = ph0_detect_q[0];
        sec_out_d     = sec_in;
        shadow_d      = start_addr_we ? start_addr_in : shadow_q;
        cursor_addr_d = cursor_we ? cursor_addr_in : cursor_addr_q;
        col_d         = col_q;
        row_d         = row_q;
        line_d        = line_q;
        scan_d        = scan_q;
        line_base_d   = line_base_q;
        frame_cnt_d   = frame_cnt_q;
        blink_on_d    = blink_on_q;
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        cursor_d      = cursor_q;
        row_out_d     = row_out_q;
        addr_d        = addr_q;
        frame_start_d = 1'b0;

        if (tick) begin
            de_d          = de_next;
            hs_d          = hs_act ? HS_POL : ~HS_POL;
            vs_d          = vs_act ? VS_POL : ~VS_POL;
            addr_d        = addr_next;
            row_out_d     = row_q;
            cursor_d      = cursor_en & blink_on_q & de_next
                          & (addr_next == cursor_addr_q) & CUR_ROWS[row_q];
            frame_start_d = (col_q == COL_LAST) && (scan_q == SCAN_LAST);

            if (col_q == COL_LAST) begin
                col_d = '0;
                if (scan_q == SCAN_LAST) begin
                    // shadow_d includes a write landing on this very clk, so it is not lost.
                    scan_d      = '0;
                    row_d       = '0;
                    line_d      = '0;
                    line_base_d = shadow_d;
                    if (BLINK_FRAMES != 0) begin
                        if (frame_cnt_q == BLINK_LAST) begin
                            frame_cnt_d = '0;
                            blink_on_d  = ~blink_on_q;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    scan_d = scan_q + 1'b1;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (line_q != LINE_LAST) begin
                            line_d      = line_q + 1'b1;
                            line_base_d = line_base_q + STRIDE;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is only ever assigned with <=, so every flop samples pre-edge values.
        if (rst) begin
            ph0_detect_q  <= '0;
            ph1_q         <= 1'b0;
            sec_out_q     <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            line_q        <= '0;
            scan_q        <= '0;
            line_base_q   <= '0;
            shadow_q      <= '0;
            cursor_addr_q <= '0;
            frame_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            cursor_q      <= 1'b0;
            frame_start_q <= 1'b0;
            row_out_q     <= '0;
            addr_q        <= '0;
        end else begin
            ph0_detect_q  <= ph0_detect_d;
            ph1_q         <= ph1_d;
            sec_out_q     <= sec_out_d;
            col_q         <= col_d;
            row_q         <= row_d;
            line_q        <= line_d;
            scan_q        <= scan_d;
            line_base_q   <= line_base_d;
            shadow_q      <= shadow_d;
            cursor_addr_q <= cursor_addr_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_on_q    <= blink_on_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            cursor_q      <= cursor_d;
            frame_start_q <= frame_start_d;
            row_out_q     <= row_out_d;
            addr_q        <= addr_d;
        end
    end

    assign ph1           = ph1_q;
    assign sec_out       = sec_out_q;
    assign de            = de_q;
    assign hs            = hs_q;
    assign vs            = vs_q;
    assign cursor        = cursor_q;
    assign frame_start   = frame_start_q;
    assign row_out       = row_out_q;
    assign video_address = addr_q;

endmodule

// File: tb/tb_vdu_crtc.sv
// Directed bench for vdu_crtc: one default-size instance plus two small-frame instances
// (active-high and active-low syncs) stepped together one character tick at a time.
module tb_vdu_crtc;

    // Small frame: H_TOTAL = 8+2+3+2 = 15, V_TOTAL = 4*3+2+2+1 = 17, frame = 255 ticks.
    localparam int S_ADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ph0 = 1'b0;
    logic sec_in = 1'b0;
    logic st_we = 1'b0;
    logic [S_ADDR_W-1:0] st_in = '0;
    logic cur_we = 1'b0;
    logic [S_ADDR_W-1:0] cur_in = '0;
    logic cur_en = 1'b0;

    logic        ph1, sec_out, de, hs, vs, cursor, frame_start;
    logic [1:0]  row_out;
    logic [4:0]  addr;

    logic        p_ph1, p_sec_out, p_de, p_hs, p_vs, p_cursor, p_frame_start;
    logic [1:0]  p_row_out;
    logic [4:0]  p_addr;

    logic        d_ph1, d_sec_out, d_de, d_hs, d_vs, d_cursor, d_frame_start;
    logic [3:0]  d_row;
    logic [12:0] d_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int dhs_cnt = 0;
    int fs_cnt  = 0;
    int cur_cnt = 0;

    always #5 clk = ~clk;

    vdu_crtc #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .ROW_LINES(4), .V_ROWS(3), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .ADDR_W(S_ADDR_W), .HS_POL(1'b1), .VS_POL(1'b1),
        .CUR_START(2), .CUR_END(3), .BLINK_FRAMES(2)
    ) u_dut (
        .clk(clk), .rst(rst), .ph0(ph0), .sec_in(sec_in), .ph1(ph1), .sec_out(sec_out),
        .start_addr_we(st_we), .start_addr_in(st_in),
        .cursor_we(cur_we), .cursor_addr_in(cur_in), .cursor_en(cur_en),
        .de(de), .hs(hs), .vs(vs), .cursor(cursor), .frame_start(frame_start),
        .row_out(row_out), .video_address(addr)
    );

    vdu_crtc #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .ROW_LINES(4), .V_ROWS(3), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .ADDR_W(S_ADDR_W), .HS_POL(1'b0), .VS_POL(1'b0),
        .CUR_START(2), .CUR_END(3), .BLINK_FRAMES(2)
    ) u_pol (
        .clk(clk), .rst(rst), .ph0(ph0), .sec_in(sec_in), .ph1(p_ph1), .sec_out(p_sec_out),
        .start_addr_we(st_we), .start_addr_in(st_in),
        .cursor_we(cur_we), .cursor_addr_in(cur_in), .cursor_en(cur_en),
        .de(p_de), .hs(p_hs), .vs(p_vs), .cursor(p_cursor), .frame_start(p_frame_start),
        .row_out(p_row_out), .video_address(p_addr)
    );

    vdu_crtc u_def (
        .clk(clk), .rst(rst), .ph0(ph0), .sec_in(sec_in), .ph1(d_ph1), .sec_out(d_sec_out),
        .start_addr_we(1'b0), .start_addr_in(13'd0),
        .cursor_we(1'b0), .cursor_addr_in(13'd0), .cursor_en(1'b0),
        .de(d_de), .hs(d_hs), .vs(d_vs), .cursor(d_cursor), .frame_start(d_frame_start),
        .row_out(d_row), .video_address(d_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One character period of 4 clks (ph0 sampled 0,0,1,1); returns on the negedge just
    // after the outputs update. wr asserts start_addr_we during the updating clk.
    task automatic tick_once(input bit wr);
        @(negedge clk);
        @(negedge clk) ph0 = 1'b1;
        @(negedge clk);
        if (wr) st_we = 1'b1;
        @(negedge clk) ph0 = 1'b0;
        st_we = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " de"}, de, 0);
        check({tag, " hs"}, hs, 0);
        check({tag, " vs"}, vs, 0);
        check({tag, " cursor"}, cursor, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " addr"}, addr, 0);
        check({tag, " row"}, row_out, 0);
        check({tag, " ph1"}, ph1, 0);
        check({tag, " sec_out"}, sec_out, 0);
        check({tag, " pol hs"}, p_hs, 1);
        check({tag, " pol vs"}, p_vs, 1);
        check({tag, " def addr"}, d_addr, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        cur_in = 5'd9;
        cur_we = 1'b1;
        @(negedge clk);
        cur_we = 1'b0;
        cur_en = 1'b1;

        for (int p = 0; p <= 1660; p++) begin
            tick_once(p == 509);
            if (p % 255 == 0) cur_cnt = 0;
            cur_cnt += int'(cursor);
            fs_cnt  += int'(frame_start);
            if (p < 100) dhs_cnt += int'(d_hs);

            case (p)
                0: begin
                    check("p0 de", de, 1);
                    check("p0 addr", addr, 0);
                    check("p0 hs", hs, 0);
                    check("p0 row", row_out, 0);
                    check("p0 frame_start", frame_start, 0);
                    check("p0 def de", d_de, 1);
                    check("p0 def addr", d_addr, 0);
                end
                7: begin
                    check("col7 addr", addr, 7);
                    check("col7 de", de, 1);
                end
                8:  check("col8 de", de, 0);
                9: begin
                    check("col9 hs", hs, 0);
                    check("col9 pol hs", p_hs, 1);
                end
                10: begin
                    check("col10 hs", hs, 1);
                    check("col10 pol hs", p_hs, 0);
                end
                12: check("col12 hs", hs, 1);
                13: check("col13 hs", hs, 0);
                15: begin
                    check("scan1 addr", addr, 0);
                    check("scan1 row", row_out, 1);
                end
                60: begin
                    check("line1 addr", addr, 8);
                    check("line1 row", row_out, 0);
                    check("line1 de", de, 1);
                end
                76: check("cursor row1 off", cursor, 0);
                79: begin
                    check("def col79 de", d_de, 1);
                    check("def col79 addr", d_addr, 79);
                end
                80: check("def col80 de", d_de, 0);
                81: check("def col81 hs", d_hs, 0);
                82: check("def col82 hs", d_hs, 1);
                91: check("cursor row2 on", cursor, 1);
                92: check("cursor col2 off", cursor, 0);
                93: check("def col93 hs", d_hs, 1);
                94: check("def col94 hs", d_hs, 0);
                99: check("def hs ticks per line", dhs_cnt, 12);
                100: begin
                    check("def scan1 addr", d_addr, 0);
                    check("def scan1 row", d_row, 1);
                    check("def scan1 hs", d_hs, 0);
                    st_in = 5'd28;
                    st_we = 1'b1;
                    @(negedge clk);
                    st_we = 1'b0;
                    st_in = 5'd0;
                end
                101: begin
                    @(negedge clk);
                    check("ph1 delayed", ph1, 1);
                end
                102: begin
                    sec_in = 1'b1;
                    @(negedge clk);
                    check("sec_out high", sec_out, 1);
                    sec_in = 1'b0;
                    @(negedge clk);
                    check("sec_out low", sec_out, 0);
                end
                106: check("cursor row3 on", cursor, 1);
                127: begin
                    check("last visible addr", addr, 23);
                    check("last visible de", de, 1);
                end
                180: check("scan12 de", de, 0);
                182: check("def line1 col82 hs", d_hs, 1);
                195: begin
                    check("scan13 vs", vs, 0);
                    check("scan13 pol vs", p_vs, 1);
                end
                210: begin
                    check("scan14 vs", vs, 1);
                    check("scan14 pol vs", p_vs, 0);
                end
                239: check("scan15 vs", vs, 1);
                240: check("scan16 vs", vs, 0);
                253: check("pre-wrap frame_start", frame_start, 0);
                254: begin
                    check("wrap frame_start", frame_start, 1);
                    check("frame0 cursor count", cur_cnt, 2);
                    @(negedge clk);
                    check("frame_start one clk", frame_start, 0);
                end
                255: begin
                    check("scrolled start addr", addr, 28);
                    check("frame1 de", de, 1);
                    check("frame1 row", row_out, 0);
                end
                315: check("scrolled line1 wrap addr", addr, 4);
                350: check("scrolled cursor", cursor, 1);
                509: check("frame1 wrap frame_start", frame_start, 1);
                510: check("same-clk start write", addr, 0);
                764: check("blink off frame2", cur_cnt, 0);
                1111: check("blink on frame4 row2", cursor, 1);
                1126: check("blink on frame4 row3", cursor, 1);
                1274: begin
                    check("frame4 cursor count", cur_cnt, 2);
                    cur_en = 1'b0;
                end
                1500: check("def row15", d_row, 15);
                1529: begin
                    check("cursor_en low count", cur_cnt, 0);
                    check("frame_start per frame", fs_cnt, 6);
                end
                1600: begin
                    check("def line1 addr", d_addr, 80);
                    check("def line1 row", d_row, 0);
                    check("def line1 de", d_de, 1);
                end
                1660: begin
                    check("pre-reset hs", hs, 1);
                    check("pre-reset addr", addr, 26);
                    check("pre-reset de", de, 0);
                end
                default: ;
            endcase
        end

        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid rst");
        @(negedge clk);
        rst = 1'b0;
        tick_once(1'b0);
        check("post rst de", de, 1);
        check("post rst addr", addr, 0);
        check("post rst row", row_out, 0);
        check("post rst hs", hs, 0);
        check("post rst pol hs", p_hs, 1);
        check("post rst def de", d_de, 1);
        check("post rst def addr", d_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
